// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core load/store
// path and the debug/loader port.
//  - Core normally wins; a 4-bit wait counter force-grants debug after MAX_WAIT
//    consecutive denied cycles so debug always makes progress.
//  - A debug grant with dbg_lock_i high opens an exclusive burst (LOCK state) of
//    at most LOCK_MAX beats, the opening ARB grant counting as the first beat.
//  - Optional macro DMEM_ARB_RR_EN: conflicts in ARB alternate between the two
//    requesters instead of using core priority plus the starvation guard.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  input  logic [3:0]        core_mask_i,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic              dbg_lock_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic [3:0]        dbg_mask_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_mask_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
  localparam logic [7:0] LOCK_LOAD_C = 8'(LOCK_MAX - 1);
  // A one-beat burst is fully served by the opening ARB grant.
  localparam logic       LOCK_EN_C   = (LOCK_MAX > 1) ? 1'b1 : 1'b0;

  state_e            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [7:0]        lock_cnt_q, lock_cnt_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              core_grant_s;
  logic              dbg_grant_s;

`ifdef DMEM_ARB_RR_EN
  // last_q: 1'b1 when debug was served most recently, 1'b0 for the core.
  localparam logic LAST_CORE = 1'b0;
  localparam logic LAST_DBG  = 1'b1;
  logic last_q, last_d;
`endif

  // Grant decision: nobody during reset, debug owns LOCK, priority rules in ARB.
  always_comb begin
    core_grant_s = 1'b0;
    dbg_grant_s  = 1'b0;
    if (rst_i) begin
      core_grant_s = 1'b0;
      dbg_grant_s  = 1'b0;
    end else begin
      case (state_q)
        ST_LOCK: begin
          core_grant_s = 1'b0;
          dbg_grant_s  = dbg_req_i;
        end
        ST_ARB: begin
          if (core_req_i && dbg_req_i) begin
`ifdef DMEM_ARB_RR_EN
            dbg_grant_s  = (last_q == LAST_CORE);
`else
            dbg_grant_s  = (wait_cnt_q == MAX_WAIT_C);
`endif
            core_grant_s = ~dbg_grant_s;
          end else begin
            core_grant_s = core_req_i;
            dbg_grant_s  = dbg_req_i;
          end
        end
        default: begin
          core_grant_s = 1'b0;
          dbg_grant_s  = 1'b0;
        end
      endcase
    end
  end

  // Next-state logic: enter LOCK on a locked debug grant, leave when the burst
  // ends; lock_cnt_q counts the LOCK beats still allowed after the current one+1.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_ARB: begin
        if (dbg_grant_s && dbg_lock_i && LOCK_EN_C) begin
          state_d    = ST_LOCK;
          lock_cnt_d = LOCK_LOAD_C;
        end else begin
          state_d    = ST_ARB;
          lock_cnt_d = 8'd0;
        end
      end
      ST_LOCK: begin
        // Exit on the beat where the decremented count reaches zero, so the
        // whole burst including the opening grant is LOCK_MAX beats long.
        if (!dbg_lock_i || !dbg_req_i || (lock_cnt_q <= 8'd1)) begin
          state_d    = ST_ARB;
          lock_cnt_d = 8'd0;
        end else begin
          state_d    = ST_LOCK;
          lock_cnt_d = lock_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d    = ST_ARB;
        lock_cnt_d = 8'd0;
      end
    endcase
  end

  // Starvation counter: counts consecutive denied debug cycles, saturating.
  always_comb begin
    wait_cnt_d = 4'd0;
    if (dbg_req_i && !dbg_grant_s) begin
      if (wait_cnt_q >= MAX_WAIT_C) begin
        wait_cnt_d = MAX_WAIT_C;
      end else begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end else begin
      wait_cnt_d = 4'd0;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Round-robin history: remember which requester was served last.
  always_comb begin
    last_d = last_q;
    if (core_grant_s) begin
      last_d = LAST_CORE;
    end else if (dbg_grant_s) begin
      last_d = LAST_DBG;
    end else begin
      last_d = last_q;
    end
  end
`endif

  // Debug read return: capture memory data on the edge ending a granted read.
  always_comb begin
    dbg_rvalid_d = dbg_grant_s & ~dbg_we_i;
    dbg_rdata_d  = dbg_rdata_q;
    if (dbg_rvalid_d) begin
      dbg_rdata_d = mem_rdata_i;
    end else begin
      dbg_rdata_d = dbg_rdata_q;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_ARB;
      wait_cnt_q   <= 4'd0;
      lock_cnt_q   <= 8'd0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Round-robin history register; resets to debug so the core wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= LAST_DBG;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Memory-side mux: the grantee drives the bus, all zeros when idle.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_mask_o  = 4'b0000;
    if (core_grant_s) begin
      mem_we_o    = core_we_i;
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
      mem_mask_o  = core_mask_i;
    end else if (dbg_grant_s) begin
      mem_we_o    = dbg_we_i;
      mem_addr_o  = dbg_addr_i;
      mem_wdata_o = dbg_wdata_i;
      mem_mask_o  = dbg_mask_i;
    end else begin
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_mask_o  = 4'b0000;
    end
  end

  assign mem_en_o     = core_grant_s | dbg_grant_s;
  assign core_stall_o = core_req_i & ~core_grant_s & ~rst_i;
  assign core_rdata_o = mem_rdata_i;
  assign dbg_gnt_o    = dbg_grant_s;
  assign dbg_rvalid_o = dbg_rvalid_q;
  assign dbg_rdata_o  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table for the listed corner cases,
// then randomized traffic checked against a transaction-level reference model.
module tb_dmem_arbiter;
  localparam int MW = 4;
  localparam int LM = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, core_req, core_we, core_stall;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [3:0]  core_mask;
  logic        dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [3:0]  dbg_mask;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_mask;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW), .LOCK_MAX(LM)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_mask_i(core_mask),
    .core_rdata_o(core_rdata), .core_stall_o(core_stall),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_lock_i(dbg_lock),
    .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata), .dbg_mask_i(dbg_mask),
    .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_mask_o(mem_mask), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] pat(int i);
    if (i == 4) return 32'hDEADBEEF;
    else if (i == 8) return 32'h12345678;
    else return 32'hA5A50000 | 32'(i * 257);
  endfunction

  // Single-port memory seen by the DUT (64 words, byte-masked writes).
  logic [31:0] tb_mem [0:63];
  logic        init_mem;
  assign mem_rdata = tb_mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= pat(i);
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) tb_mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        rst, cr, cw;
    logic [31:0] ca, cd;
    logic [3:0]  cm;
    logic        dr, dw, dl;
    logic [31:0] da, dd;
    logic [3:0]  dm;
    logic        e_stall, e_gnt, e_rv;
    int          rd_sel;   // 0 none, 1 check core_rdata, 2 check dbg_rdata
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic cr, input logic cw, input logic [31:0] ca,
                              input logic dr, input logic dw, input logic dl, input logic [31:0] da,
                              input logic [31:0] dd, input logic [3:0] dm,
                              input logic es, input logic eg, input logic erv);
    vec_t v;
    v.rst = r; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = ~ca; v.cm = 4'hF;
    v.dr = dr; v.dw = dw; v.dl = dl; v.da = da; v.dd = dd; v.dm = dm;
    v.e_stall = es; v.e_gnt = eg; v.e_rv = erv; v.rd_sel = 0; v.e_rd = 32'h0;
    return v;
  endfunction

  // Reference model: who gets each cycle, how long a debug burst has run,
  // how long debug has been kept waiting, and the expected memory image.
  bit          m_locked, m_last_dbg, m_rv;
  int          m_used, m_waits;
  logic [31:0] m_rd;
  logic [31:0] ref_mem [0:63];

  task automatic model_reset();
    m_locked = 1'b0; m_used = 0; m_waits = 0; m_last_dbg = 1'b1; m_rv = 1'b0; m_rd = 32'h0;
  endtask

  task automatic run(input vec_t v, output bit g_c, output bit g_d);
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_mask;
    logic        e_we;
    @(negedge clk);
    rst = v.rst; core_req = v.cr; core_we = v.cw; core_addr = v.ca; core_wdata = v.cd;
    core_mask = v.cm; dbg_req = v.dr; dbg_we = v.dw; dbg_lock = v.dl; dbg_addr = v.da;
    dbg_wdata = v.dd; dbg_mask = v.dm;
    #1;
    g_c = 1'b0; g_d = 1'b0;
    if (!v.rst) begin
      if (m_locked) g_d = v.dr;
      else if (v.cr && v.dr) begin
`ifdef DMEM_ARB_RR_EN
        g_d = !m_last_dbg;
`else
        g_d = (m_waits == MW);
`endif
        g_c = !g_d;
      end else begin
        g_c = v.cr; g_d = v.dr;
      end
    end
    if (g_c) begin
      e_we = v.cw; e_addr = v.ca; e_wd = v.cd; e_mask = v.cm;
    end else if (g_d) begin
      e_we = v.dw; e_addr = v.da; e_wd = v.dd; e_mask = v.dm;
    end else begin
      e_we = 1'b0; e_addr = 32'h0; e_wd = 32'h0; e_mask = 4'h0;
    end
    chk("core_stall", 32'(core_stall), 32'(v.cr && !v.rst && !g_c));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(g_d));
    chk("mem_en", 32'(mem_en), 32'(g_c || g_d));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("mem_mask", 32'(mem_mask), 32'(e_mask));
    chk("core_rdata", core_rdata, ref_mem[e_addr[7:2]]);
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_rv));
    chk("dbg_rdata", dbg_rdata, m_rd);
    if (v.rst) begin
      model_reset();
    end else begin
      if (g_d && !v.dw) m_rd = ref_mem[v.da[7:2]];
      m_rv = g_d && !v.dw;
      if ((g_c || g_d) && e_we)
        for (int b = 0; b < 4; b++)
          if (e_mask[b]) ref_mem[e_addr[7:2]][8*b +: 8] = e_wd[8*b +: 8];
      if (v.dr && !g_d) m_waits = (m_waits + 1 > MW) ? MW : m_waits + 1;
      else m_waits = 0;
      if (g_c) m_last_dbg = 1'b0;
      if (g_d) m_last_dbg = 1'b1;
      if (m_locked) begin
        if (g_d) m_used++;
        if (!v.dl || !v.dr || m_used >= LM) m_locked = 1'b0;
      end else if (g_d && v.dl && LM > 1) begin
        m_locked = 1'b1; m_used = 1;
      end
    end
  endtask

  vec_t vecs[$];
  vec_t v;
  bit   gc, gd, hold_c, hold_d;

  initial begin
    rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
    core_mask = 4'h0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0; dbg_addr = 32'h0;
    dbg_wdata = 32'h0; dbg_mask = 4'h0; init_mem = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    model_reset();
    repeat (2) @(negedge clk);
    init_mem = 1'b0;

`ifdef DMEM_ARB_RR_EN
    vecs.push_back(mk(1, 1, 0, 32'h10, 1, 0, 0, 32'h20, 32'h0, 4'hF, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h10, 1, 0, 0, 32'h20, 32'h0, 4'hF, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h10, 1, 0, 0, 32'h20, 32'h0, 4'hF, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h10, 1, 0, 0, 32'h20, 32'h0, 4'hF, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 32'h10, 1, 0, 0, 32'h20, 32'h0, 4'hF, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 1));
`else
    // reset, then a plain core read of preloaded 0xDEADBEEF
    vecs.push_back(mk(1, 1, 0, 32'h10, 1, 0, 0, 32'h20, 32'h0, 4'hF, 0, 0, 0));
    v = mk(0, 1, 0, 32'h10, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    v.rd_sel = 1; v.e_rd = 32'hDEADBEEF; vecs.push_back(v);
    // starvation: four denials, forced grant on the fifth, data one cycle later
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 1, 0, 32'h10, 1, 0, 0, 32'h20, 32'h0, 4'hF, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h10, 1, 0, 0, 32'h20, 32'h0, 4'hF, 1, 1, 0));
    v = mk(0, 1, 0, 32'h14, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 1);
    v.rd_sel = 2; v.e_rd = 32'h12345678; vecs.push_back(v);
    // locked write burst: lock held 12 cycles, exactly 8 beats granted
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 1, 0, 32'h18, 1, 1, 1, 32'h40, 32'h1000, 4'hF, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 1, 0, 32'h18, 1, 1, 1, 32'h40 + 32'(4 * k), 32'h1000 + 32'(k), 4'hF, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h18, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0));
    // reset on the third LOCK cycle
    vecs.push_back(mk(0, 0, 0, 32'h0, 1, 0, 1, 32'h20, 32'h0, 4'hF, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h10, 1, 0, 1, 32'h24, 32'h0, 4'hF, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 32'h10, 1, 0, 1, 32'h28, 32'h0, 4'hF, 1, 1, 1));
    vecs.push_back(mk(1, 1, 0, 32'h10, 1, 0, 1, 32'h2C, 32'h0, 4'hF, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 32'h10, 1, 0, 1, 32'h2C, 32'h0, 4'hF, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0, 1, 0, 0, 32'h2C, 32'h0, 4'hF, 0, 1, 0));
    // masked debug write, no read return afterwards
    vecs.push_back(mk(0, 0, 0, 32'h0, 1, 1, 0, 32'h30, 32'hAA, 4'b0001, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0));
    // dbg_req dropped inside LOCK: no grant, core still stalled that cycle
    vecs.push_back(mk(0, 0, 0, 32'h0, 1, 0, 1, 32'h24, 32'h0, 4'hF, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h10, 1, 0, 1, 32'h28, 32'h0, 4'hF, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 32'h10, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 32'h10, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0));
`endif

    foreach (vecs[i]) begin
      run(vecs[i], gc, gd);
      chk($sformatf("row%0d stall", i), 32'(core_stall), 32'(vecs[i].e_stall));
      chk($sformatf("row%0d gnt", i), 32'(dbg_gnt), 32'(vecs[i].e_gnt));
      chk($sformatf("row%0d rvalid", i), 32'(dbg_rvalid), 32'(vecs[i].e_rv));
      if (vecs[i].rd_sel == 1) chk($sformatf("row%0d core_rdata", i), core_rdata, vecs[i].e_rd);
      if (vecs[i].rd_sel == 2) chk($sformatf("row%0d dbg_rdata", i), dbg_rdata, vecs[i].e_rd);
    end

    // randomized traffic; requesters hold their fields until served
    hold_c = 1'b0; hold_d = 1'b0;
    for (int n = 0; n < 800; n++) begin
      v.rst = ($urandom_range(0, 79) == 0);
      if (!hold_c) begin
        v.cr = ($urandom_range(0, 9) < 7); v.cw = 1'($urandom_range(0, 1));
        v.ca = {24'h0, 6'($urandom), 2'b00}; v.cd = $urandom; v.cm = 4'($urandom);
      end
      if (!hold_d) begin
        v.dr = ($urandom_range(0, 9) < 6); v.dw = 1'($urandom_range(0, 1));
        v.da = {24'h0, 6'($urandom), 2'b00}; v.dd = $urandom; v.dm = 4'($urandom);
      end
      v.dl = ($urandom_range(0, 9) < 8);
      run(v, gc, gd);
      hold_c = v.cr && !gc && !v.rst;
      hold_d = v.dr && !gd && !v.rst;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter placed between the single-cycle core's load/store path and the single-port data memory. A second requester, the debug/loader port, can preload or inspect data memory while the core runs. The core normally wins. A starvation counter guarantees debug progress, and a lock mode gives debug exclusive bursts. Whenever the core is denied, the arbiter stalls it for that cycle.

## Interface
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: data width.
- `MAX_WAIT`, 4: number of consecutive denied debug cycles before debug is force-granted (range 1..15).
- `LOCK_MAX`, 8: maximum length of a debug lock burst, in cycles (range 1..255).
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `core_req` in 1: core memory access this cycle.
- `core_we` in 1: core write enable.
- `core_addr` in ADDR_W: core byte address.
- `core_wdata` in DATA_W: core write data.
- `core_mask` in 4: core byte-write mask.
- `core_rdata` out DATA_W: core read data, combinational.
- `core_stall` out 1: core access not performed this cycle; the core holds its PC and request.
- `dbg_req` in 1: debug access request.
- `dbg_we` in 1: debug write enable.
- `dbg_lock` in 1: debug requests a locked burst.
- `dbg_addr` in ADDR_W: debug byte address.
- `dbg_wdata` in DATA_W: debug write data.
- `dbg_mask` in 4: debug byte-write mask.
- `dbg_gnt` out 1: debug access performed this cycle.
- `dbg_rvalid` out 1: registered read-return strobe for debug.
- `dbg_rdata` out DATA_W: registered debug read data.
- `mem_en` out 1: memory access enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_mask` out 4: memory byte mask.
- `mem_rdata` in DATA_W: combinational memory read data.

## Operation
- There are two states: ARB and LOCK.
- In ARB, with fixed priority:
  - Only core requests: core granted.
  - Only debug requests: debug granted.
  - Both request: core granted, unless `wait_cnt == MAX_WAIT`, in which case debug is granted.
- `wait_cnt` (4-bit):
  - Increments on each cycle debug requests and is denied.
  - Clears on every debug grant, and on any cycle with `dbg_req` low.
  - Saturates at MAX_WAIT.
- ARB→LOCK: on a debug grant with `dbg_lock` high. `lock_cnt` loads LOCK_MAX-1.
- In LOCK:
  - Debug owns the memory.
  - `core_stall` is high whenever `core_req` is high.
  - `lock_cnt` decrements each cycle.
- LOCK→ARB: when `dbg_lock` is low, or `dbg_req` is low, or `lock_cnt == 0`, whichever comes first. That cycle is still granted to debug if `dbg_req` is high.
- Memory-side mux:
  - Grantee's fields drive `mem_*`.
  - `mem_en = core_grant | dbg_gnt`.
  - All `mem_*` are zero when idle.
- `core_rdata = mem_rdata` always. It is valid only when `core_stall` is low.
- `core_stall = core_req & ~core_grant`.
- Debug reads: `dbg_rdata` captures `mem_rdata` on the clock edge of a granted debug read. `dbg_rvalid` pulses one cycle later. Debug writes produce no rvalid.

## Timing
- Core access: zero-latency. Grant and read data arrive in the same cycle, and writes commit at the next edge.
- Debug read: grant in cycle N, `dbg_rvalid`/`dbg_rdata` in cycle N+1.
- Reset values:
  - State ARB; `wait_cnt` 0; `lock_cnt` 0.
  - `dbg_rvalid` 0; `dbg_rdata` 0.
  - `core_stall` 0 and `dbg_gnt` 0 while `rst` is high.
  - All `mem_*` 0 while `rst` is high.
- Reset mid-LOCK: returns to ARB at the next edge. A pending `dbg_rvalid` is cleared.
- `dbg_req` dropped mid-LOCK: exit to ARB with no grant that cycle.
- Simultaneous forced debug grant and `dbg_lock`: enters LOCK.
- Requester contract: both requesters must hold request fields stable until served.

## Configuration
- `DMEM_ARB_RR_EN`
  - Defined: on conflict in ARB, grant alternates via a 1-bit `last` register. The requester not served most recently wins, and `wait_cnt` forcing is disabled. `last` resets to debug, so the core wins the first conflict.
  - Undefined: fixed core priority with the MAX_WAIT starvation guard, as described in Operation.
  - LOCK behaviour is identical in both modes.

## Test plan
- Core only, read address 0x10 with memory content 0xDEADBEEF → `core_rdata` 0xDEADBEEF in the same cycle, `core_stall` 0, `dbg_gnt` 0.
- Continuous core requests plus debug read of 0x20 (MAX_WAIT=4) → debug denied 4 cycles, granted on the 5th cycle with `core_stall` 1 that cycle; `dbg_rvalid` on the 6th cycle with correct data.
- Debug locked write burst at 0x40..0x5C, `dbg_lock` held for 12 cycles, LOCK_MAX=8 → exactly 8 consecutive `dbg_gnt`, core stalled for those 8, then ARB resumes with core granted.
- `rst` asserted on the 3rd cycle of LOCK → next cycle: ARB, `dbg_rvalid` 0, core granted.
- With `DMEM_ARB_RR_EN`, both requesting continuously → grant sequence core, dbg, core, dbg…; `core_stall` toggles 0,1,0,1.
- Debug write 0x0000_00AA with mask 4'b0001 to 0x30 while core idle → `mem_we` 1, `mem_mask` 4'b0001, no `dbg_rvalid`.
